fast_field_decode_stream: RTL

//  Parametrised successor to the fixed 3-message FAST decode stage. Decodes a byte stream of

---
 rtl/fast_pkg.sv | 12 +
 rtl/fast_field_decode_stream_if.sv | 29 ++
 rtl/fast_stopbit_accum.sv | 36 +++
 rtl/fast_field_decode_stream.sv | 117 +++++++++++
 4 files changed

// File: rtl/fast_pkg.sv
// fast_pkg: FAST stop-bit constants, error-flag positions and decoder FSM states
package fast_pkg;
    localparam int FAST_STOP_BIT     = 7;
    localparam int FAST_PAYLOAD_BITS = 7;
    localparam int ERR_OVF   = 0;
    localparam int ERR_LONG  = 1;
    localparam int ERR_TRUNC = 2;
    localparam int ERR_CHSW  = 3;
    localparam int ERR_MANY  = 4;
    localparam int ERR_W     = 5;
    typedef enum logic [1:0] {IDLE, ACCUM, DROP} state_t;
endpackage

// File: rtl/fast_field_decode_stream_if.sv
// fast_field_decode_stream_if: byte-in / field-out handshake bundle of the FAST decoder
interface fast_field_decode_stream_if #(
    parameter int CH_W       = 2,
    parameter int FIELD_BITS = 64,
    parameter int IDX_W      = 4,
    parameter int NB_W       = 4
);
    logic                  s_valid;
    logic                  s_ready;
    logic [7:0]            s_data;
    logic [CH_W-1:0]       s_ch;
    logic                  s_last;
    logic                  m_valid;
    logic                  m_ready;
    logic [FIELD_BITS-1:0] m_field;
    logic [CH_W-1:0]       m_ch;
    logic [IDX_W-1:0]      m_idx;
    logic [NB_W-1:0]       m_nbytes;
    logic                  m_last;
    logic                  m_err;
    modport slave (
        input  s_valid, s_data, s_ch, s_last, m_ready,
        output s_ready, m_valid, m_field, m_ch, m_idx, m_nbytes, m_last, m_err
    );
    modport master (
        output s_valid, s_data, s_ch, s_last, m_ready,
        input  s_ready, m_valid, m_field, m_ch, m_idx, m_nbytes, m_last, m_err
    );
endinterface

// File: rtl/fast_stopbit_accum.sv
// fast_stopbit_accum: stop-bit accumulator; outputs already include the byte shifted in this cycle
module fast_stopbit_accum import fast_pkg::*; #(
    parameter int FIELD_BITS = 64,
    parameter int NB_W       = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         shift_en,
    input  logic [FAST_PAYLOAD_BITS-1:0] byte_in,
    output logic [FIELD_BITS-1:0]        acc,
    output logic [NB_W-1:0]              nbytes,
    output logic                         ovf
);
    logic [FIELD_BITS-1:0] acc_q;
    logic [FIELD_BITS-1:0] base;
    logic [NB_W-1:0]       nb_q;
    logic                  ovf_q;
    always_comb begin
        base   = clear ? '0 : acc_q;
        acc    = shift_en ? {base[FIELD_BITS-FAST_PAYLOAD_BITS-1:0], byte_in} : base;
        nbytes = (clear ? '0 : nb_q) + NB_W'(shift_en);
        ovf    = (!clear & ovf_q) | (shift_en & |base[FIELD_BITS-1 -: FAST_PAYLOAD_BITS]);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            nb_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc;
            nb_q  <= nbytes;
            ovf_q <= ovf;
        end
    end
endmodule

// File: rtl/fast_field_decode_stream.sv
// fast_field_decode_stream: multi-channel FAST stop-bit field decoder with backpressure and counters
module fast_field_decode_stream import fast_pkg::*; #(
    parameter int NUM_CH          = 3,
    parameter int FIELD_BITS      = 64,
    parameter int MAX_FIELD_BYTES = 10,
    parameter int MAX_FIELDS      = 16,
    parameter int CNT_BITS        = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    fast_field_decode_stream_if.slave  io,
    output logic [NUM_CH*CNT_BITS-1:0] msg_cnt,
    output logic [CNT_BITS-1:0]        err_cnt
);
    localparam int CH_W  = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int IDX_W = $clog2(MAX_FIELDS);
    localparam int NB_W  = $clog2(MAX_FIELD_BYTES + 1);
    localparam int FI_W  = $clog2(MAX_FIELDS + 1);
    state_t                state;
    logic                  up, pend, hold_last, out_free, go, sw, drop, shift_en, clear, done, emit;
    logic                  e_stop, e_last, ovf;
    logic [7:0]            hold_data, e_data;
    logic [CH_W-1:0]       hold_ch, e_ch, cur_ch;
    logic [FI_W-1:0]       fidx;
    logic [FIELD_BITS-1:0] acc;
    logic [NB_W-1:0]       nbytes;
    logic [ERR_W-1:0]      err_v;
    // A channel switch closes the open field and parks the new byte for one cycle (pend)
    always_comb begin
        out_free   = !io.m_valid | io.m_ready;
        io.s_ready = up & out_free & !pend;
        go         = out_free & (pend | (up & io.s_valid));
        e_data     = pend ? hold_data : io.s_data;
        e_ch       = pend ? hold_ch : io.s_ch;
        e_last     = pend ? hold_last : io.s_last;
        e_stop     = e_data[FAST_STOP_BIT];
        sw         = state == ACCUM && e_ch != cur_ch;
        drop       = state == DROP && e_ch == cur_ch;
        shift_en   = go & !sw & !drop;
        clear      = state != ACCUM;
        done       = e_stop | e_last | (nbytes == NB_W'(MAX_FIELD_BYTES));
        emit       = go & !drop & (sw | done);
        err_v            = '0;
        err_v[ERR_OVF]   = ovf;
        err_v[ERR_LONG]  = !sw & !e_stop & !e_last;
        err_v[ERR_TRUNC] = !sw & !e_stop & e_last;
        err_v[ERR_CHSW]  = sw;
        err_v[ERR_MANY]  = fidx == FI_W'(MAX_FIELDS);
    end
    fast_stopbit_accum #(.FIELD_BITS(FIELD_BITS), .NB_W(NB_W)) u_accum (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .shift_en (shift_en),
        .byte_in  (e_data[FAST_PAYLOAD_BITS-1:0]),
        .acc      (acc),
        .nbytes   (nbytes),
        .ovf      (ovf)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            up          <= 1'b0;
            pend        <= 1'b0;
            hold_data   <= '0;
            hold_ch     <= '0;
            hold_last   <= 1'b0;
            cur_ch      <= '0;
            fidx        <= '0;
            io.m_valid  <= 1'b0;
            io.m_field  <= '0;
            io.m_ch     <= '0;
            io.m_idx    <= '0;
            io.m_nbytes <= '0;
            io.m_last   <= 1'b0;
            io.m_err    <= 1'b0;
        end else begin
            up <= 1'b1;
            if (go) begin
                pend <= sw;
                if (sw) begin
                    hold_data <= e_data;
                    hold_ch   <= e_ch;
                    hold_last <= e_last;
                end
                state <= sw ? IDLE :
                         drop ? ((e_stop | e_last) ? IDLE : DROP) :
                         !done ? ACCUM : ((e_stop | e_last) ? IDLE : DROP);
                if (shift_en) cur_ch <= e_ch;
                if (drop & e_last) fidx <= '0;
            end
            if (emit) begin
                io.m_valid  <= 1'b1;
                io.m_field  <= acc;
                io.m_ch     <= sw ? cur_ch : e_ch;
                io.m_idx    <= (fidx == FI_W'(MAX_FIELDS)) ? IDX_W'(MAX_FIELDS - 1) : fidx[IDX_W-1:0];
                io.m_nbytes <= nbytes;
                io.m_last   <= sw | e_last;
                io.m_err    <= |err_v;
                fidx        <= (sw | e_last) ? '0 : (fidx == FI_W'(MAX_FIELDS)) ? fidx : fidx + FI_W'(1);
            end else if (out_free) begin
                io.m_valid <= 1'b0;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msg_cnt <= '0;
            err_cnt <= '0;
        end else if (io.m_valid & io.m_ready) begin
            for (int k = 0; k < NUM_CH; k++)
                if (io.m_last && io.m_ch == CH_W'(k))
                    msg_cnt[k*CNT_BITS +: CNT_BITS] <= msg_cnt[k*CNT_BITS +: CNT_BITS] + CNT_BITS'(1);
            if (io.m_err && !(&err_cnt)) err_cnt <= err_cnt + CNT_BITS'(1);
        end
    end
endmodule
